cutting_seq_ctrl: RTL and testbench
===================================

Name: cutting_seq_ctrl

Overview:
Run-time sequencer for the half-bridge ultrasonic drive. It replaces the free-running Din command decode with a state machine that drives the ICO/phase-tracking datapath through four phases: idle, frequency sweep with minimum-|theta| search, settle at the best point, and closed-loop tracking. It also supervises lock during tracking. Its outputs set_point, sweep and stop feed the existing increment mux and gate blanking.

Parameters:
START_SP, 15'd12460, first sweep increment value
END_SP, 15'd16940, last permitted sweep increment, inclusive
STEP_SP, 15'd32, increment step per dwell
DWELL, 8, drive cycles spent at each sweep point
SETTLE, 32, drive cycles held at the best point before tracking
LOCK_TH, 8'd40, abs_theta above this is counted as out of lock
LOSS_CNT, 16, consecutive out-of-lock cycles that declare lock loss

Ports:
clk40MHz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
din  in  5  external command code, asynchronous to clk40MHz
cycle_tick  in  1  one-clk pulse per drive cycle, issued after abs_theta has updated
abs_theta  in  8  per-cycle phase count from the phase detector
set_point  out  15  increment used while sweep=1
sweep  out  1  1 = open loop at set_point; 0 = phase tracking
stop  out  1  1 = both gates held low
locked  out  1  high in TRACK while in lock
fault  out  1  sticky lock-loss flag
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset values:
  - state = IDLE
  - set_point = START_SP, sweep = 1, stop = 1
  - locked = 0, fault = 0
  - all counters = 0
- Command input:
  - din passes through a 2-flop synchronizer.
  - A command is accepted when the synchronized value equals the previous sample and differs from the last accepted code.
  - Each command takes effect once, 3-4 clocks after din settles.
- Commands:
  - 0..20 = preset. Only in IDLE: set_point <= din*224 + 12460, computed as (din<<8) - (din<<5) + 12460 in 15 bits.
  - 21 = START. From IDLE or FAULT; also clears fault.
  - 22 = HALT. From any state go to IDLE; set_point is kept.
  - 25 = ABORT. Go to IDLE, set_point = START_SP, clear fault.
  - All other codes are ignored.
- IDLE: stop=1, sweep=1.
  - START loads set_point = START_SP, clears best_theta to 8'hFF, and goes to SWEEP.
- SWEEP: stop=0, sweep=1.
  - The dwell counter counts cycle_tick.
  - On the DWELL-th tick, sample abs_theta. If abs_theta < best_theta (strict, so the first minimum wins on ties), store best_theta and best_sp.
  - Then, if set_point + STEP_SP > END_SP (16-bit compare), go to SETTLE. Otherwise set_point += STEP_SP.
- SETTLE: set_point = best_sp, sweep=1, stop=0.
  - After SETTLE ticks, go to TRACK.
- TRACK: sweep=0, stop=0.
  - The loss counter increments on each tick where abs_theta > LOCK_TH and resets on any tick at or below LOCK_TH.
  - locked = (loss counter == 0).
  - When the counter reaches LOSS_CNT: fault=1, go to FAULT.
- FAULT: stop=1, sweep=1, locked=0.
  - Leave only on START (go to SWEEP) or ABORT/HALT (go to IDLE).
- Timing and priorities:
  - All outputs are registered, so a state change is visible one clk after the deciding event.
  - HALT/ABORT take priority over a cycle_tick in the same clk.
  - A tick arriving during a command's accept clock is processed normally.
- Reset mid-sweep returns everything to the reset values immediately (asynchronous).
- cycle_tick inputs are ignored in IDLE and FAULT.

Optional Feature:
AUTO_RESWEEP_EN
- Defined: lock loss in TRACK sets fault=1 for one clk as a pulse and re-enters SWEEP from START_SP. Drive continues with stop=0. A 4-bit resweep counter saturates at 15, and the 4th consecutive loss goes to FAULT with fault sticky.
- Undefined: lock loss goes to FAULT as described in Behaviour.

Decomposition:
- Package cutting_pkg holds:
  - the state enum (IDLE=0, SWEEP=1, SETTLE=2, TRACK=3, FAULT=4)
  - the command code constants CMD_START=21, CMD_HALT=22, CMD_ABORT=25
  - SP_W=15
- Sub-module cutting_cmd_sync covers the synchronizer plus change-detect; it outputs a one-clk cmd_valid and a 5-bit cmd.

Test Plan:
- Reset, then din=5 -> set_point=13580, stop=1, sweep=1; then din=21 -> stop=0, set_point=12460 within 4 clks.
- START with abs_theta = |set_point - 14700|/16, saturated at 255 -> best_sp=14700; 141 sweep points (12460..16940); SETTLE outputs 14700; sweep=0 after 32 more ticks.
- Same sweep with two equal minima at 13996 and 14028 -> best_sp=13996.
- TRACK, then abs_theta=60 for 15 ticks, 10 for 1 tick, then 60 for 16 ticks -> fault=1 only on the 16th consecutive tick; stop=1.
- din=22 mid-SWEEP coincident with cycle_tick -> IDLE next clk, set_point unchanged, no step applied.
- din held at 21 continuously -> exactly one START accepted; rst_n low mid-TRACK -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/cutting_pkg.sv
// Shared types and constants for the ultrasonic cutting run-time sequencer.
//   - state_e   : sequencer state encoding, also exported on state_o for debug
//   - CMD_*     : din command codes with a special meaning
//   - preset_sp : maps a preset code (0..20) onto a set_point value
package cutting_pkg;

  localparam int SP_W = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    SETTLE = 3'd2,
    TRACK  = 3'd3,
    FAULT  = 3'd4
  } state_e;

  localparam logic [4:0] CMD_PRESET_MAX = 5'd20;
  localparam logic [4:0] CMD_START      = 5'd21;
  localparam logic [4:0] CMD_HALT       = 5'd22;
  localparam logic [4:0] CMD_ABORT      = 5'd25;

  // c*224 + base, built from shifts so it maps onto adders only
  function automatic logic [SP_W-1:0] preset_sp(input logic [4:0] c,
                                                input logic [SP_W-1:0] base);
    logic [SP_W-1:0] cw;
    cw = {{(SP_W-5){1'b0}}, c};
    return (cw << 8) - (cw << 5) + base;
  endfunction

endpackage

// File: rtl/cutting_cmd_sync.sv
// Command input conditioning for the sequencer.
// din_i is asynchronous: a 2-flop synchronizer brings it into the clk domain,
// then a code is accepted once it has been stable for two samples and differs
// from the last code accepted, so each command fires exactly once.
// Ports:
//   clk40MHz, rst_n : clock, async active-low reset
//   din_i           : raw external command code
//   cmd_valid_o     : one-clk strobe, new command accepted
//   cmd_o           : accepted command code
module cutting_cmd_sync (
  input  logic       clk40MHz,
  input  logic       rst_n,
  input  logic [4:0] din_i,
  output logic       cmd_valid_o,
  output logic [4:0] cmd_o
);

  logic [4:0] s1_q, s2_q, prev_q, last_q;

  // last_q resets to an ignored code, so whatever din holds out of reset is
  // seen as a fresh command
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      last_q <= 5'h1F;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (cmd_valid_o) last_q <= s2_q;
    end
  end

  assign cmd_valid_o = (s2_q == prev_q) && (s2_q != last_q);
  assign cmd_o       = s2_q;

endmodule

// File: rtl/cutting_seq_ctrl.sv
// Run-time sequencer for the half-bridge ultrasonic drive:
// IDLE -> SWEEP (minimum |theta| search) -> SETTLE (hold best point) ->
// TRACK (closed loop, lock supervision) -> FAULT on lock loss.
// Ports:
//   clk40MHz, rst_n : clock, async active-low reset
//   din             : async command code (preset 0..20, START, HALT, ABORT)
//   cycle_tick      : one-clk pulse per drive cycle, abs_theta valid
//   abs_theta       : per-cycle phase magnitude
//   set_point       : open-loop increment (used while sweep=1)
//   sweep, stop     : increment-mux select and gate blanking
//   locked, fault   : lock status and sticky lock-loss flag
//   state_o         : current state, debug
// Build option AUTO_RESWEEP_EN: lock loss pulses fault and restarts the
// sweep; only the 4th consecutive loss lands in FAULT.
module cutting_seq_ctrl
  import cutting_pkg::*;
#(
  parameter logic [SP_W-1:0] START_SP = 15'd12460,
  parameter logic [SP_W-1:0] END_SP   = 15'd16940,
  parameter logic [SP_W-1:0] STEP_SP  = 15'd32,
  parameter int              DWELL    = 8,
  parameter int              SETTLE_N = 32,
  parameter logic [7:0]      LOCK_TH  = 8'd40,
  parameter int              LOSS_CNT = 16
) (
  input  logic            clk40MHz,
  input  logic            rst_n,
  input  logic [4:0]      din,
  input  logic            cycle_tick,
  input  logic [7:0]      abs_theta,
  output logic [SP_W-1:0] set_point,
  output logic            sweep,
  output logic            stop,
  output logic            locked,
  output logic            fault,
  output logic [2:0]      state_o
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam int ST_W = $clog2(SETTLE_N + 1);
  localparam int LS_W = $clog2(LOSS_CNT + 1);

  logic       cmd_valid;
  logic [4:0] cmd;

  cutting_cmd_sync u_cmd_sync (
    .clk40MHz   (clk40MHz),
    .rst_n      (rst_n),
    .din_i      (din),
    .cmd_valid_o(cmd_valid),
    .cmd_o      (cmd)
  );

  state_e            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d, best_sp_q, best_sp_d;
  logic [7:0]        best_th_q, best_th_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [LS_W-1:0]   loss_q, loss_d;
  logic              fault_q, fault_d, locked_q, locked_d;
  logic              sweep_q, sweep_d, stop_q, stop_d;
  logic [SP_W-1:0]   cand_sp;
  logic [7:0]        cand_th;
`ifdef AUTO_RESWEEP_EN
  logic [3:0]        resweep_q, resweep_d;
`endif

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    best_sp_d = best_sp_q;
    best_th_d = best_th_q;
    dwell_d   = dwell_q;
    settle_d  = settle_q;
    loss_d    = loss_q;
    fault_d   = fault_q;
    cand_sp   = best_sp_q;
    cand_th   = best_th_q;
`ifdef AUTO_RESWEEP_EN
    resweep_d = resweep_q;
`endif

    // drive-cycle driven progress; cycle_tick has no effect in IDLE/FAULT
    case (state_q)
      SWEEP: begin
        // fault can only be high here as a one-clk resweep pulse
        fault_d = 1'b0;
        if (cycle_tick) begin
          if (dwell_q == DW_W'(DWELL - 1)) begin
            dwell_d = '0;
            // strict compare: on ties the earliest point is kept
            if (abs_theta < best_th_q) begin
              cand_th = abs_theta;
              cand_sp = sp_q;
            end
            best_th_d = cand_th;
            best_sp_d = cand_sp;
            if ({1'b0, sp_q} + {1'b0, STEP_SP} > {1'b0, END_SP}) begin
              state_d  = SETTLE;
              sp_d     = cand_sp;
              settle_d = '0;
            end else begin
              sp_d = sp_q + STEP_SP;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cycle_tick) begin
          if (settle_q == ST_W'(SETTLE_N - 1)) begin
            state_d  = TRACK;
            settle_d = '0;
            loss_d   = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      TRACK: begin
        if (cycle_tick) begin
          loss_d = (abs_theta > LOCK_TH) ? loss_q + 1'b1 : '0;
          if (loss_d == LS_W'(LOSS_CNT)) begin
            loss_d  = '0;
            fault_d = 1'b1;
`ifdef AUTO_RESWEEP_EN
            resweep_d = (resweep_q == 4'hF) ? 4'hF : resweep_q + 1'b1;
            if (resweep_q >= 4'd3) begin
              state_d = FAULT;
            end else begin
              state_d   = SWEEP;
              sp_d      = START_SP;
              best_th_d = 8'hFF;
              best_sp_d = START_SP;
              dwell_d   = '0;
            end
`else
            state_d = FAULT;
`endif
          end
        end
      end
      default: ;
    endcase

    // commands override any tick processing in the same clk
    if (cmd_valid) begin
      case (cmd)
        CMD_START: begin
          if (state_q == IDLE || state_q == FAULT) begin
            state_d   = SWEEP;
            sp_d      = START_SP;
            best_th_d = 8'hFF;
            best_sp_d = START_SP;
            dwell_d   = '0;
            settle_d  = '0;
            loss_d    = '0;
            fault_d   = 1'b0;
`ifdef AUTO_RESWEEP_EN
            resweep_d = '0;
`endif
          end
        end
        CMD_HALT, CMD_ABORT: begin
          state_d  = IDLE;
          dwell_d  = '0;
          settle_d = '0;
          loss_d   = '0;
          if (cmd == CMD_ABORT) begin
            sp_d    = START_SP;
            fault_d = 1'b0;
`ifdef AUTO_RESWEEP_EN
            resweep_d = '0;
`endif
          end else begin
            sp_d    = sp_q;
            fault_d = (state_q == SWEEP) ? 1'b0 : fault_q;
          end
        end
        default: begin
          if (cmd <= CMD_PRESET_MAX && state_q == IDLE)
            sp_d = preset_sp(cmd, START_SP);
        end
      endcase
    end

    // outputs registered from the next state
    sweep_d  = (state_d != TRACK);
    stop_d   = (state_d == IDLE) || (state_d == FAULT);
    locked_d = (state_d == TRACK) && (loss_d == '0);
  end

  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sp_q      <= START_SP;
      best_sp_q <= START_SP;
      best_th_q <= 8'hFF;
      dwell_q   <= '0;
      settle_q  <= '0;
      loss_q    <= '0;
      fault_q   <= 1'b0;
      locked_q  <= 1'b0;
      sweep_q   <= 1'b1;
      stop_q    <= 1'b1;
`ifdef AUTO_RESWEEP_EN
      resweep_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      best_sp_q <= best_sp_d;
      best_th_q <= best_th_d;
      dwell_q   <= dwell_d;
      settle_q  <= settle_d;
      loss_q    <= loss_d;
      fault_q   <= fault_d;
      locked_q  <= locked_d;
      sweep_q   <= sweep_d;
      stop_q    <= stop_d;
`ifdef AUTO_RESWEEP_EN
      resweep_q <= resweep_d;
`endif
    end
  end

  assign set_point = sp_q;
  assign sweep     = sweep_q;
  assign stop      = stop_q;
  assign locked    = locked_q;
  assign fault     = fault_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cutting_seq_ctrl.sv
// Directed bench for cutting_seq_ctrl: command decode, sweep minimum search,
// tie handling, settle/track, lock loss, HALT priority and async reset.
module tb_cutting_seq_ctrl;

  logic        clk40MHz;
  logic        rst_n;
  logic [4:0]  din;
  logic        cycle_tick;
  logic [7:0]  abs_theta;
  logic [14:0] set_point;
  logic        sweep, stop, locked, fault;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  cutting_seq_ctrl dut (
    .clk40MHz  (clk40MHz),
    .rst_n     (rst_n),
    .din       (din),
    .cycle_tick(cycle_tick),
    .abs_theta (abs_theta),
    .set_point (set_point),
    .sweep     (sweep),
    .stop      (stop),
    .locked    (locked),
    .fault     (fault),
    .state_o   (state_o)
  );

  initial clk40MHz = 1'b0;
  always #12 clk40MHz = ~clk40MHz;

  // called at a negedge; pulse lands on the next posedge, returns at a negedge
  task automatic tick(input logic [7:0] th);
    abs_theta  = th;
    cycle_tick = 1'b1;
    @(negedge clk40MHz);
    cycle_tick = 1'b0;
    @(negedge clk40MHz);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk40MHz);
  endtask

  // plant model: mode 0 single minimum at 14700, mode 1 tie at 13996/14028,
  // mode 2 flat response
  function automatic logic [7:0] plant(input logic [14:0] sp, input int mode);
    int c, d;
    c = (mode == 0) ? 14700 : 14012;
    d = (int'(sp) > c) ? int'(sp) - c : c - int'(sp);
    d = d / 16;
    if (mode == 2) d = 50;
    return (d > 255) ? 8'd255 : 8'(d);
  endfunction

  task automatic run_sweep(input int mode, output int npts);
    logic [14:0] cur;
    npts = 0;
    for (int p = 0; p < 200; p++) begin
      if (state_o != 3'd1) break;
      cur = set_point;
      repeat (8) tick(plant(cur, mode));
      npts++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = 5'd0; cycle_tick = 1'b0; abs_theta = 8'd0;
    wait_clks(3);
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++; if (set_point !== 15'd12460) begin errors++; $display("FAIL reset_sp got %0d want 12460", set_point); end
    checks++; if ({sweep, stop, locked, fault} !== 4'b1100) begin errors++; $display("FAIL reset_flags got %b want 1100", {sweep, stop, locked, fault}); end
    rst_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic test_preset_start;
    din = 5'd5;
    wait_clks(6);
    checks++; if (set_point !== 15'd13580) begin errors++; $display("FAIL preset_sp got %0d want 13580", set_point); end
    checks++; if ({sweep, stop} !== 2'b11 || state_o !== 3'd0) begin errors++; $display("FAIL preset_idle got %b/%0d want 11/0", {sweep, stop}, state_o); end
    din = 5'd21;
    wait_clks(4);
    checks++; if (stop !== 1'b0 || state_o !== 3'd1) begin errors++; $display("FAIL start_lat stop/state got %b/%0d want 0/1", stop, state_o); end
    checks++; if (set_point !== 15'd12460) begin errors++; $display("FAIL start_sp got %0d want 12460", set_point); end
  endtask

  task automatic test_sweep_min;
    int n;
    run_sweep(0, n);
    checks++; if (n !== 141) begin errors++; $display("FAIL sweep_points got %0d want 141", n); end
    checks++; if (state_o !== 3'd2 || set_point !== 15'd14700) begin errors++; $display("FAIL settle_sp got %0d/%0d want 2/14700", state_o, set_point); end
    checks++; if ({sweep, stop} !== 2'b10) begin errors++; $display("FAIL settle_flags got %b want 10", {sweep, stop}); end
    repeat (31) tick(8'd0);
    checks++; if (sweep !== 1'b1) begin errors++; $display("FAIL settle_hold sweep got %b want 1", sweep); end
    tick(8'd0);
    checks++; if (sweep !== 1'b0 || state_o !== 3'd3 || locked !== 1'b1) begin errors++; $display("FAIL track_entry got %b/%0d/%b want 0/3/1", sweep, state_o, locked); end
  endtask

  task automatic test_tie;
    int n;
    din = 5'd22;
    wait_clks(6);
    checks++; if (state_o !== 3'd0 || stop !== 1'b1) begin errors++; $display("FAIL halt_track got %0d/%b want 0/1", state_o, stop); end
    din = 5'd21;
    wait_clks(6);
    run_sweep(1, n);
    checks++; if (state_o !== 3'd2 || set_point !== 15'd13996) begin errors++; $display("FAIL tie_best got %0d/%0d want 2/13996", state_o, set_point); end
    repeat (32) tick(8'd0);
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL tie_track got %0d want 3", state_o); end
  endtask

  task automatic test_lock_loss;
    repeat (15) tick(8'd60);
    checks++; if (locked !== 1'b0 || fault !== 1'b0 || state_o !== 3'd3) begin errors++; $display("FAIL loss15 got %b/%b/%0d want 0/0/3", locked, fault, state_o); end
    tick(8'd10);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
    repeat (15) tick(8'd60);
    checks++; if (fault !== 1'b0 || state_o !== 3'd3) begin errors++; $display("FAIL loss_pre got %b/%0d want 0/3", fault, state_o); end
    tick(8'd60);
    checks++; if (fault !== 1'b1 || stop !== 1'b1 || sweep !== 1'b1 || state_o !== 3'd4 || locked !== 1'b0) begin errors++; $display("FAIL loss16 got f%b s%b w%b st%0d l%b want 1 1 1 4 0", fault, stop, sweep, state_o, locked); end
  endtask

  task automatic test_halt_coincident;
    din = 5'd25;
    wait_clks(6);
    checks++; if (fault !== 1'b0 || state_o !== 3'd0 || set_point !== 15'd12460) begin errors++; $display("FAIL abort got %b/%0d/%0d want 0/0/12460", fault, state_o, set_point); end
    din = 5'd21;
    wait_clks(6);
    repeat (8) tick(8'd100);
    checks++; if (set_point !== 15'd12492) begin errors++; $display("FAIL step_sp got %0d want 12492", set_point); end
    repeat (7) tick(8'd100);
    din = 5'd22;
    wait_clks(3);
    abs_theta  = 8'd0;
    cycle_tick = 1'b1;
    @(negedge clk40MHz);
    cycle_tick = 1'b0;
    checks++; if (state_o !== 3'd0 || set_point !== 15'd12492 || stop !== 1'b1) begin errors++; $display("FAIL halt_tick got %0d/%0d/%b want 0/12492/1", state_o, set_point, stop); end
    wait_clks(2);
  endtask

  task automatic test_start_held;
    int n;
    din = 5'd21;
    wait_clks(6);
    checks++; if (state_o !== 3'd1 || set_point !== 15'd12460) begin errors++; $display("FAIL held_start got %0d/%0d want 1/12460", state_o, set_point); end
    run_sweep(2, n);
    checks++; if (set_point !== 15'd12460 || state_o !== 3'd2) begin errors++; $display("FAIL flat_best got %0d/%0d want 12460/2", set_point, state_o); end
    repeat (32) tick(8'd0);
    repeat (16) tick(8'd60);
    wait_clks(10);
    checks++; if (state_o !== 3'd4 || fault !== 1'b1) begin errors++; $display("FAIL held_once got %0d/%b want 4/1", state_o, fault); end
  endtask

  task automatic test_reset_mid_track;
    int n;
    din = 5'd25;
    wait_clks(6);
    din = 5'd21;
    wait_clks(6);
    run_sweep(0, n);
    repeat (32) tick(8'd0);
    checks++; if (state_o !== 3'd3 || locked !== 1'b1 || sweep !== 1'b0) begin errors++; $display("FAIL pre_rst got %0d/%b/%b want 3/1/0", state_o, locked, sweep); end
    #5 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 3'd0 || set_point !== 15'd12460 || {sweep, stop, locked, fault} !== 4'b1100) begin errors++; $display("FAIL async_rst got %0d/%0d/%b want 0/12460/1100", state_o, set_point, {sweep, stop, locked, fault}); end
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  initial begin
    test_reset;
    test_preset_start;
    test_sweep_min;
    test_tie;
    test_lock_loss;
    test_halt_coincident;
    test_start_held;
    test_reset_mid_track;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
